// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler
//   Round-robin scheduler that shares one external 64-bit combinational ALU
//   between NUM_REQ requesters. One operation is in flight at a time:
//   accept -> hold operands on the ALU for EXEC_CYCLES cycles -> register the
//   result -> return it with the owner id on a valid/ready response channel.
//
// Optional feature (compile-time macro): ALU_OP_CHECK_EN
//   When defined, op[2]==1 is illegal: the op bypasses the ALU entirely and
//   answers with rsp_data=0, rsp_err=1. When undefined, rsp_err is tied 0.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
//   valid and ready are both 1. Requests: req_valid[i] & req_ready[i], with
//   req_ready one-hot and only ever high in IDLE. Responses: rsp_valid &
//   rsp_ready; rsp_data/rsp_id/rsp_err are stable while rsp_valid waits.
//
// Ports
//   clk, rstn            clock (rising edge), async active-low reset
//   req_valid/req_ready  per-requester request handshake
//   req_a/b/c            packed operands, requester i at [64*i +: 64]
//   req_op, req_nbits    packed 3-bit op code / width select per requester
//   alu_a/b/c/op/nbits   operands to the shared ALU (hold last values)
//   alu_enable           high only while the ALU is executing
//   alu_out              ALU result, sampled on the last execute cycle
//   rsp_valid/rsp_ready  response handshake
//   rsp_data/id/err      result, owning requester, illegal-op flag
//   done_count           completed responses, wraps at 16 bits
//   state_dbg            current FSM state (0 idle, 1 exec, 2 resp)
module alu_req_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int EXEC_CYCLES = 2,
  parameter int IDW         = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*64-1:0] req_a,
  input  logic [NUM_REQ*64-1:0] req_b,
  input  logic [NUM_REQ*64-1:0] req_c,
  input  logic [NUM_REQ*3-1:0] req_op,
  input  logic [NUM_REQ*3-1:0] req_nbits,
  output logic [63:0]          alu_a,
  output logic [63:0]          alu_b,
  output logic [63:0]          alu_c,
  output logic [2:0]           alu_op,
  output logic [2:0]           alu_nbits,
  output logic                 alu_enable,
  input  logic [63:0]          alu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  output logic [15:0]          done_count,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Down-counter holds values EXEC_CYCLES-1 .. 0.
  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   exec_cnt;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  grant_next_ptr;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [63:0]     grant_a, grant_b, grant_c;
  logic [2:0]      grant_op, grant_nbits;
  logic            grant_illegal;
  logic            accept;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin : arb
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant_next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDW'(1);
    grant_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
    grant_a        = req_a[int'(grant_idx)*64 +: 64];
    grant_b        = req_b[int'(grant_idx)*64 +: 64];
    grant_c        = req_c[int'(grant_idx)*64 +: 64];
    grant_op       = req_op[int'(grant_idx)*3 +: 3];
    grant_nbits    = req_nbits[int'(grant_idx)*3 +: 3];
  end

`ifdef ALU_OP_CHECK_EN
  assign grant_illegal = grant_op[2];
`else
  assign grant_illegal = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          accept  = 1'b1;
          state_d = grant_illegal ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: if (exec_cnt == '0) state_d = ST_RESP;
      ST_RESP: if (rsp_ready)      state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // req_ready is gated by rstn so it reads 0 while reset is held even if
  // requesters keep valid asserted.
  assign req_ready  = (accept && rstn) ? grant_onehot : '0;
  assign alu_enable = (state_q == ST_EXEC);
  assign rsp_valid  = (state_q == ST_RESP);
  assign state_dbg  = state_q;

  // Datapath: latch on accept, sample alu_out on the last execute cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr     <= '0;
      exec_cnt   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_c      <= '0;
      alu_op     <= '0;
      alu_nbits  <= '0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      done_count <= '0;
    end else begin
      if (accept) begin
        rr_ptr   <= grant_next_ptr;
        rsp_id   <= grant_idx;
        exec_cnt <= CW'(EXEC_CYCLES - 1);
        if (grant_illegal) begin
          // Illegal ops never reach the ALU; its inputs keep their old values.
          rsp_data <= '0;
        end else begin
          alu_a     <= grant_a;
          alu_b     <= grant_b;
          alu_c     <= grant_c;
          alu_op    <= grant_op;
          alu_nbits <= grant_nbits;
        end
      end
      if (state_q == ST_EXEC) begin
        if (exec_cnt == '0) rsp_data <= alu_out;
        else                exec_cnt <= exec_cnt - CW'(1);
      end
      if (state_q == ST_RESP && rsp_ready) done_count <= done_count + 16'd1;
    end
  end

`ifdef ALU_OP_CHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       rsp_err <= 1'b0;
    else if (accept) rsp_err <= grant_illegal;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: models the shared ALU, keeps a response
// scoreboard, and walks through reset, single op, fairness, back-pressure,
// MAC, reset-during-exec, illegal op and back-to-back traffic.
module tb_alu_req_scheduler;
  localparam int NUM_REQ     = 4;
  localparam int EXEC_CYCLES = 2;
  localparam int IDW         = 2;
  localparam int EW          = 1 + IDW + 64;

  logic                   clk;
  logic                   rstn;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*64-1:0]  req_a, req_b, req_c;
  logic [NUM_REQ*3-1:0]   req_op, req_nbits;
  logic [63:0]            alu_a, alu_b, alu_c;
  logic [2:0]             alu_op, alu_nbits;
  logic                   alu_enable;
  logic [63:0]            alu_out;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [63:0]            rsp_data;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_err;
  logic [15:0]            done_count;
  logic [1:0]             state_dbg;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  alu_req_scheduler #(.NUM_REQ(NUM_REQ), .EXEC_CYCLES(EXEC_CYCLES), .IDW(IDW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_op(req_op), .req_nbits(req_nbits),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .alu_op(alu_op), .alu_nbits(alu_nbits), .alu_enable(alu_enable),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .done_count(done_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU model ----------------
  function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c, input logic [2:0] op,
                                            input logic [2:0] nbits);
    logic [63:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a * b;
      3'b010:  r = a - b;
      3'b011:  r = a * b + c;
      default: r = a ^ b;
    endcase
    case (nbits)
      3'd0:    r = {56'd0, r[7:0]};
      3'd1:    r = {48'd0, r[15:0]};
      3'd2:    r = {32'd0, r[31:0]};
      default: r = r;
    endcase
    return r;
  endfunction

  // Garbage when disabled, so sampling outside execute shows up as wrong data.
  assign alu_out = alu_enable ? alu_model(alu_a, alu_b, alu_c, alu_op, alu_nbits)
                              : 64'hBADC_0FFE_E0DD_F00D;

  function automatic logic [EW-1:0] expect_for(input int g);
    logic [2:0] op;
    op = req_op[3*g +: 3];
`ifdef ALU_OP_CHECK_EN
    if (op[2]) return {1'b1, IDW'(g), 64'd0};
`endif
    return {1'b0, IDW'(g), alu_model(req_a[64*g +: 64], req_b[64*g +: 64], req_c[64*g +: 64],
                                     op, req_nbits[3*g +: 3])};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rstn) begin
      for (int g = 0; g < NUM_REQ; g++)
        if (req_valid[g] && req_ready[g]) exp_q.push_back(expect_for(g));
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got err=%b id=%0d data=%h, required no response",
                   rsp_err, rsp_id, rsp_data);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if ({rsp_err, rsp_id, rsp_data} !== e) begin
            fails++;
            $display("FAIL sb_response: got err=%b id=%0d data=%h, required err=%b id=%0d data=%h",
                     rsp_err, rsp_id, rsp_data, e[EW-1], e[64 +: IDW], e[63:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [2:0] op, input logic [2:0] nbits);
    req_a[64*i +: 64]   = a;
    req_b[64*i +: 64]   = b;
    req_c[64*i +: 64]   = c;
    req_op[3*i +: 3]    = op;
    req_nbits[3*i +: 3] = nbits;
  endtask

  // Issues one request and follows it to rsp_valid. lat counts negedges after
  // the accept edge until rsp_valid is seen; en counts alu_enable cycles.
  task automatic run_op(input int i, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [2:0] op, input logic [2:0] nbits,
                        output int lat, output int en, output logic [63:0] data,
                        output logic [IDW-1:0] id, output logic err, output bit ok);
    int guard;
    bit seen;
    set_req(i, a, b, c, op, nbits);
    req_valid[i] = 1'b1;
    ok = 1'b0; guard = 0; lat = 0; en = 0; seen = 1'b0;
    data = '0; id = '0; err = 1'b0;
    while (!ok && guard < 20) begin
      @(negedge clk);
      guard++;
      if (req_ready[i]) ok = 1'b1;
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    if (ok) begin
      while (!seen && lat < 50) begin
        @(negedge clk);
        lat++;
        if (alu_enable) en++;
        if (rsp_valid) begin
          seen = 1'b1; data = rsp_data; id = rsp_id; err = rsp_err;
        end
      end
      ok = seen;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int guard;
    guard = 0; ok = 1'b0;
    while (!ok && guard < 100) begin
      @(negedge clk);
      guard++;
      if (state_dbg == 2'd0 && !rsp_valid) ok = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; req_valid = '1; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_op = '0; req_nbits = '0;
    @(negedge clk);
    tests++;
    if (req_ready !== '0) begin
      fails++; $display("FAIL reset_req_ready: got %b, required 0", req_ready);
    end
    tests++;
    if ({alu_enable, rsp_valid, rsp_err, rsp_id, alu_op, alu_nbits, done_count, state_dbg} !== '0) begin
      fails++;
      $display("FAIL reset_ctrl: got en=%b rv=%b err=%b id=%0d op=%0d nb=%0d done=%0d st=%0d, required all 0",
               alu_enable, rsp_valid, rsp_err, rsp_id, alu_op, alu_nbits, done_count, state_dbg);
    end
    tests++;
    if ({alu_a, alu_b, alu_c, rsp_data} !== '0) begin
      fails++;
      $display("FAIL reset_data: got a=%h b=%h c=%h rsp=%h, required 0", alu_a, alu_b, alu_c, rsp_data);
    end
    req_valid = '0;
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_single_op();
    int lat, en; logic [63:0] d; logic [IDW-1:0] id; logic err; bit ok;
    logic [15:0] dc0;
    dc0 = done_count;
    rsp_ready = 1'b1;
    run_op(0, 64'd5, 64'd3, 64'd0, 3'b000, 3'd0, lat, en, d, id, err, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_timeout: got no response, required one"); end
    tests++;
    if (lat !== EXEC_CYCLES + 1) begin
      fails++; $display("FAIL single_latency: got %0d, required %0d", lat, EXEC_CYCLES + 1);
    end
    tests++;
    if (en !== EXEC_CYCLES) begin
      fails++; $display("FAIL single_enable_cycles: got %0d, required %0d", en, EXEC_CYCLES);
    end
    tests++;
    if ({err, id, d} !== {1'b0, IDW'(0), 64'd8}) begin
      fails++; $display("FAIL single_result: got err=%b id=%0d data=%h, required err=0 id=0 data=8", err, id, d);
    end
    tests++;
    if (done_count !== dc0 + 16'd1) begin
      fails++; $display("FAIL single_done_count: got %0d, required %0d", done_count, dc0 + 16'd1);
    end
  endtask

  task automatic test_fairness();
    int grants, guard;
    bit ok;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 64'(i * 7 + 1), 64'(i + 100), 64'd0, 3'b000, 3'd3);
    req_valid = '1;
    grants = 0; guard = 0;
    while (grants < 8 && guard < 200) begin
      @(negedge clk);
      guard++;
      for (int g = 0; g < NUM_REQ; g++) begin
        if (req_valid[g] && req_ready[g]) begin
          tests++;
          if (g !== grants % NUM_REQ) begin
            fails++; $display("FAIL fair_order: grant %0d got req%0d, required req%0d", grants, g, grants % NUM_REQ);
          end
          grants++;
        end
      end
    end
    @(posedge clk);
    #1 req_valid = '0;
    tests++;
    if (grants !== 8) begin fails++; $display("FAIL fair_timeout: got %0d grants, required 8", grants); end
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL fair_drain: got busy, required idle"); end
    tests++;
    if (done_count !== 16'd8) begin
      fails++; $display("FAIL fair_done_count: got %0d, required 8", done_count);
    end
  endtask

  task automatic test_back_pressure();
    int lat, en; logic [63:0] d; logic [IDW-1:0] id; logic err; bit ok;
    logic [15:0] dc0;
    dc0 = done_count;
    rsp_ready = 1'b0;
    run_op(3, 64'd100, 64'd1, 64'd0, 3'b010, 3'd1, lat, en, d, id, err, ok);
    tests++;
    if (!ok || {err, id, d} !== {1'b0, IDW'(3), 64'd99}) begin
      fails++; $display("FAIL bp_result: got ok=%b err=%b id=%0d data=%h, required id=3 data=63", ok, err, id, d);
    end
    set_req(1, 64'd1, 64'd1, 64'd0, 3'b000, 3'd0);
    req_valid[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      tests++;
      if ({rsp_valid, rsp_err, rsp_id, rsp_data} !== {1'b1, 1'b0, IDW'(3), 64'd99}) begin
        fails++; $display("FAIL bp_rsp_hold: cycle %0d got v=%b id=%0d data=%h, required v=1 id=3 data=63",
                          k, rsp_valid, rsp_id, rsp_data);
      end
      tests++;
      if (req_ready !== '0 || alu_enable !== 1'b0) begin
        fails++; $display("FAIL bp_quiet: cycle %0d got ready=%b en=%b, required 0 0", k, req_ready, alu_enable);
      end
    end
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || done_count !== dc0 + 16'd1) begin
      fails++; $display("FAIL bp_release: got v=%b done=%0d, required v=0 done=%0d", rsp_valid, done_count, dc0 + 16'd1);
    end
  endtask

  task automatic test_mac32();
    int lat, en; logic [63:0] d; logic [IDW-1:0] id; logic err; bit ok;
    rsp_ready = 1'b1;
    run_op(2, 64'h10, 64'h10, 64'h1, 3'b011, 3'd2, lat, en, d, id, err, ok);
    tests++;
    if (!ok || {err, id, d} !== {1'b0, IDW'(2), 64'h101} || lat !== EXEC_CYCLES + 1) begin
      fails++; $display("FAIL mac32: got ok=%b lat=%0d id=%0d data=%h, required lat=%0d id=2 data=101",
                        ok, lat, id, d, EXEC_CYCLES + 1);
    end
  endtask

  task automatic test_reset_mid_exec();
    int guard, rv_seen;
    bit ok;
    rsp_ready = 1'b1;
    set_req(1, 64'd40, 64'd2, 64'd0, 3'b000, 3'd3);
    req_valid[1] = 1'b1;
    ok = 1'b0; guard = 0;
    while (!ok && guard < 20) begin
      @(negedge clk); guard++;
      if (req_ready[1]) ok = 1'b1;
    end
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    tests++;
    if (!ok || alu_enable !== 1'b1) begin
      fails++; $display("FAIL rst_mid_setup: got ok=%b en=%b, required 1 1", ok, alu_enable);
    end
    #1 rstn = 1'b0;
    exp_q.delete();
    #1;
    tests++;
    if ({req_ready, alu_enable, rsp_valid, rsp_err, rsp_id, alu_op, alu_nbits, done_count, state_dbg} !== '0 ||
        {alu_a, alu_b, alu_c, rsp_data} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: got en=%b rv=%b a=%h done=%0d st=%0d, required all 0",
                        alu_enable, rsp_valid, alu_a, done_count, state_dbg);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    rv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) rv_seen++;
    end
    tests++;
    if (rv_seen !== 0) begin
      fails++; $display("FAIL rst_mid_no_rsp: got %0d rsp_valid cycles, required 0", rv_seen);
    end
    @(posedge clk);
    #1 req_valid = '1;
    @(negedge clk);
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL rst_mid_next_grant: got %b, required 0001", req_ready);
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rst_mid_drain: got busy, required idle"); end
  endtask

  task automatic test_illegal_op();
    int lat, en; logic [63:0] d; logic [IDW-1:0] id; logic err; bit ok;
    logic [63:0] a0;
    a0 = alu_a;
    rsp_ready = 1'b1;
    run_op(1, 64'h1234, 64'h00FF, 64'd0, 3'b100, 3'd3, lat, en, d, id, err, ok);
    tests++;
`ifdef ALU_OP_CHECK_EN
    if (!ok || {err, id, d} !== {1'b1, IDW'(1), 64'd0} || en !== 0 || lat !== 1 || alu_a !== a0) begin
      fails++; $display("FAIL illegal_op: got ok=%b err=%b id=%0d data=%h en=%0d lat=%0d alu_a=%h, required err=1 id=1 data=0 en=0 lat=1 alu_a=%h",
                        ok, err, id, d, en, lat, alu_a, a0);
    end
`else
    if (!ok || {err, id, d} !== {1'b0, IDW'(1), 64'h12CB} || en !== EXEC_CYCLES ||
        lat !== EXEC_CYCLES + 1 || alu_a === a0) begin
      fails++; $display("FAIL illegal_op: got ok=%b err=%b id=%0d data=%h en=%0d lat=%0d, required err=0 id=1 data=12cb en=%0d lat=%0d",
                        ok, err, id, d, en, lat, EXEC_CYCLES, EXEC_CYCLES + 1);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int cyc, n, guard;
    int t[3];
    bit ok;
    rsp_ready = 1'b1;
    set_req(0, 64'd9, 64'd4, 64'd0, 3'b001, 3'd0);
    req_valid = 4'b0001;
    cyc = 0; n = 0; guard = 0;
    while (n < 3 && guard < 100) begin
      @(negedge clk);
      cyc++; guard++;
      if (req_valid[0] && req_ready[0]) begin t[n] = cyc; n++; end
    end
    @(posedge clk);
    #1 req_valid = '0;
    tests++;
    if (n !== 3 || t[1] - t[0] !== EXEC_CYCLES + 2 || t[2] - t[1] !== EXEC_CYCLES + 2) begin
      fails++; $display("FAIL b2b_throughput: got %0d grants gaps %0d %0d, required 3 grants gap %0d",
                        n, t[1] - t[0], t[2] - t[1], EXEC_CYCLES + 2);
    end
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)));
      req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(ok);
    tests++;
    if (!ok || exp_q.size() !== 0) begin
      fails++; $display("FAIL b2b_drain: got idle=%b pending=%0d, required idle=1 pending=0", ok, exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_back_pressure();
    test_mac32();
    test_reset_mid_exec();
    test_illegal_op();
    test_back_to_back();
    repeat (2) @(posedge clk);
    tests++;
    if (exp_q.size() !== 0) begin
      fails++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
